cur_fetch: RTL and testbench

- Frame-side source for the current-block path: answers the CurBuffer's `read_en` requests with 32-bit words of the current frame.
- Walks the frame block by block (raster order of BLK x BLK pixel blocks), and rows/columns in raster order inside each block.
- Generates read addresses for a synchronous single-port frame SRAM.
- Returns each word one cycle after the request and reports block/frame completion.

---
 rtl/me_pkg.sv | 32 +++
 rtl/cur_fetch_if.sv | 37 +++
 rtl/blk_addr_gen.sv | 63 ++++++
 rtl/cur_fetch.sv | 80 ++++++++
 tb/tb_cur_fetch.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared constants, derived geometry and FSM encoding
// for the current-block fetch path.
package me_pkg;

  localparam int unsigned FRAME_W = 64;
  localparam int unsigned FRAME_H = 64;
  localparam int unsigned BLK     = 16;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 10;

  localparam int unsigned WPR = FRAME_W * 8 / DW;
  localparam int unsigned WB  = BLK * 8 / DW;
  localparam int unsigned NBX = FRAME_W / BLK;
  localparam int unsigned NBY = FRAME_H / BLK;

  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BXW = cw(NBX);
  localparam int unsigned BYW = cw(NBY);
  localparam int unsigned RW  = cw(BLK);
  localparam int unsigned CW  = cw(WB);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/cur_fetch_if.sv
// CurBuffer request/response and frame SRAM bus
// bundled for the current-block fetcher.
interface cur_fetch_if;
  import me_pkg::*;

  logic          read_en;
  logic          next_block;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] cur_data;
  logic          cur_valid;
  logic          block_done;

  modport master (
    input  read_en,
    input  next_block,
    input  mem_rdata,
    output mem_rd,
    output mem_addr,
    output cur_data,
    output cur_valid,
    output block_done
  );

  modport slave (
    output read_en,
    output next_block,
    output mem_rdata,
    input  mem_rd,
    input  mem_addr,
    input  cur_data,
    input  cur_valid,
    input  block_done
  );

endinterface

// File: rtl/blk_addr_gen.sv
// Block-raster walker: block position, in-block row/col
// and the frame SRAM word address they select.
module blk_addr_gen
  import me_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_word,
  input  logic          adv_block,
  input  logic          clear,
  output logic [AW-1:0] addr,
  output logic          last_word,
  output logic          last_block
);

  logic [BXW-1:0] bx;
  logic [BYW-1:0] by;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;

  logic bx_wrap;
  logic col_wrap;

  assign col_wrap   = (col == CW'(WB - 1));
  assign bx_wrap    = (bx == BXW'(NBX - 1));
  assign last_word  = (row == RW'(BLK - 1)) && col_wrap;
  assign last_block = bx_wrap && (by == BYW'(NBY - 1));

  assign addr = AW'((32'(by) * BLK + 32'(row)) * WPR
                    + 32'(bx) * WB + 32'(col));

  // releasing the final block parks everything at block 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bx  <= '0;
      by  <= '0;
      row <= '0;
      col <= '0;
    end else if (clear || (adv_block && last_block)) begin
      bx  <= '0;
      by  <= '0;
      row <= '0;
      col <= '0;
    end else if (adv_block) begin
      row <= '0;
      col <= '0;
      if (bx_wrap) begin
        bx <= '0;
        by <= by + 1'b1;
      end else begin
        bx <= bx + 1'b1;
      end
    end else if (inc_word) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cur_fetch.sv
// Current-block fetch: request FSM plus the one-deep
// read-data/valid stage toward the CurBuffer.
module cur_fetch
  import me_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       frame_done,
  output logic       busy,
  cur_fetch_if.master bus
);

  state_t state_q, state_d;

  logic run, hold, idle_like;
  logic rd, adv, clr;
  logic last_word, last_block;
  logic vld_q, bd_q, fd_q;
  logic [DW-1:0] data_q;

  assign run       = (state_q == RUN);
  assign hold      = (state_q == HOLD);
  assign idle_like = (state_q == IDLE) || (state_q == DONE);

  assign rd  = run & bus.read_en & ~bus.next_block;
  assign adv = (run | hold) & bus.next_block;
  assign clr = idle_like & start;

  blk_addr_gen u_addr (
    .clk        (clk),
    .rst        (rst),
    .inc_word   (rd),
    .adv_block  (adv),
    .clear      (clr),
    .addr       (bus.mem_addr),
    .last_word  (last_word),
    .last_block (last_block)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN: begin
        if (adv)
          state_d = last_block ? DONE : RUN;
        else if (rd && last_word)
          state_d = HOLD;
      end
      HOLD: if (adv) state_d = last_block ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      bd_q    <= 1'b0;
      fd_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= rd;
      bd_q    <= rd & last_word;
      fd_q    <= adv & last_block;
      if (vld_q) data_q <= bus.mem_rdata;
    end
  end

  // SRAM output is live only in the return cycle
  assign bus.cur_data   = vld_q ? bus.mem_rdata : data_q;
  assign bus.cur_valid  = vld_q;
  assign bus.block_done = bd_q;
  assign bus.mem_rd     = rd;
  assign frame_done     = fd_q;
  assign busy           = run | hold;

endmodule

// File: tb/tb_cur_fetch.sv
// Scoreboard bench for cur_fetch: directed block walks,
// early release, restart and asynchronous reset.
module tb_cur_fetch;
  import me_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic frame_done;
  logic busy;

  cur_fetch_if bus();

  cur_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_done (frame_done),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [32:0] sbq[$];
  logic [32:0] mon_e;

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return (32'h9E37_79B1 * 32'(a)) ^ 32'h0BAD_F00D;
  endfunction

  function automatic int waddr(input int bx, input int by, input int k);
    return (by * 16 + k / 4) * 16 + bx * 4 + k % 4;
  endfunction

  // synchronous SRAM model: data one cycle after the strobe
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.mem_rdata <= '0;
    else if (bus.mem_rd) bus.mem_rdata <= pat(bus.mem_addr);
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (bus.cur_valid) begin
      chk("sb_depth", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("cur_data", bus.cur_data, mon_e[31:0]);
        chk("block_done", 32'(bus.block_done), 32'(mon_e[32]));
      end
    end else begin
      chk("stray_block_done", 32'(bus.block_done), 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, input bit last);
    bus.read_en    = 1'b1;
    bus.next_block = 1'b0;
    @(negedge clk);
    chk("mem_rd", 32'(bus.mem_rd), 1);
    chk("mem_addr", 32'(bus.mem_addr), a);
    sbq.push_back({last, pat(AW'(a))});
    cyc();
    bus.read_en = 1'b0;
  endtask

  task automatic rd_block(input int bx, input int by);
    for (int k = 0; k < 64; k++) rd(waddr(bx, by, k), k == 63);
  endtask

  task automatic nb(input bit re);
    bus.next_block = 1'b1;
    bus.read_en    = re;
    @(negedge clk);
    chk("nb_mem_rd", 32'(bus.mem_rd), 0);
    cyc();
    bus.next_block = 1'b0;
    bus.read_en    = 1'b0;
  endtask

  task automatic no_rd(input string n);
    bus.read_en = 1'b1;
    @(negedge clk);
    chk(n, 32'(bus.mem_rd), 0);
    cyc();
    bus.read_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic chk_quiet(input string n);
    chk({n, "_mem_rd"}, 32'(bus.mem_rd), 0);
    chk({n, "_mem_addr"}, 32'(bus.mem_addr), 0);
    chk({n, "_cur_valid"}, 32'(bus.cur_valid), 0);
    chk({n, "_cur_data"}, bus.cur_data, 0);
    chk({n, "_block_done"}, 32'(bus.block_done), 0);
    chk({n, "_frame_done"}, 32'(frame_done), 0);
    chk({n, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int b0[8] = '{0, 1, 2, 3, 16, 17, 18, 19};
  int b1[5] = '{4, 5, 6, 7, 20};

  initial begin
    bus.read_en    = 1'b0;
    bus.next_block = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    no_rd("idle_ignore");
    pulse_start();
    @(negedge clk);
    chk("busy_run", 32'(busy), 1);
    cyc();

    for (int k = 0; k < 8; k++) rd(b0[k], 1'b0);
    for (int k = 8; k < 64; k++) rd(waddr(0, 0, k), k == 63);
    no_rd("hold_ignore");
    no_rd("hold_ignore2");
    @(negedge clk);
    chk("busy_hold", 32'(busy), 1);
    cyc();
    nb(1'b0);

    for (int k = 0; k < 5; k++) rd(b1[k], 1'b0);
    for (int k = 5; k < 64; k++) rd(waddr(1, 0, k), k == 63);
    nb(1'b0);
    rd_block(2, 0);
    nb(1'b0);
    rd_block(3, 0);
    nb(1'b0);

    rd(256, 1'b0);
    for (int k = 1; k < 63; k++) rd(waddr(0, 1, k), 1'b0);
    rd(499, 1'b1);
    nb(1'b0);

    for (int b = 5; b < 16; b++) begin
      rd_block(b % 4, b / 4);
      nb(1'b0);
    end
    repeat (3) cyc();
    chk("frame_done_cnt", fd_cnt, 1);
    chk("busy_done", 32'(busy), 0);
    no_rd("done_ignore");

    pulse_start();
    for (int k = 0; k < 10; k++) rd(waddr(0, 0, k), 1'b0);
    nb(1'b1);
    rd(4, 1'b0);
    start = 1'b1;
    rd(5, 1'b0);
    start = 1'b0;
    rd(6, 1'b0);

    bus.read_en = 1'b1;
    @(negedge clk);
    chk("pre_rst_mem_rd", 32'(bus.mem_rd), 1);
    @(posedge clk);
    #1;
    bus.read_en = 1'b0;
    chk("pre_rst_valid", 32'(bus.cur_valid), 1);
    rst = 1'b0;
    #1;
    chk_quiet("async_rst");
    @(negedge clk);
    rst = 1'b1;
    cyc();
    no_rd("post_rst_ignore");
    no_rd("post_rst_ignore2");
    chk("sb_empty", sbq.size(), 0);
    chk("frame_done_total", fd_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
